// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate, logical and arithmetic shifts in either
// direction. A tag travels with each operation. Valid/ready handshakes are
// provided on both sides, and the whole pipe stalls at once.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !(out_valid && !out_ready)
//   in_data  [WIDTH]    operand
//   in_amnt  [SHW]      shift amount, 0..WIDTH-1
//   in_dir              0 = right, 1 = left
//   in_mode  [2]        00 logical, 01 arithmetic, 1x rotate
//   in_tag   [TAG_W]    sideband tag, returned unmodified
//   out_valid/out_ready output handshake
//   out_data [WIDTH]    shifted result (registered)
//   out_tag  [TAG_W]    tag of the result (registered)
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SHW       = $clog2(WIDTH),
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amnt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned NREG = (SHW + REG_EVERY - 1) / REG_EVERY;

  logic stall;

  // One mux stage: shift by the constant sh according to direction and mode.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] x,
    input int unsigned      sh,
    input logic             left,
    input logic [1:0]       mode,
    input logic             sign
  );
    logic [WIDTH-1:0] res;
    res = x;
    if (mode[1]) begin
      res = left ? ((x << sh) | (x >> (WIDTH - sh)))
                 : ((x >> sh) | (x << (WIDTH - sh)));
    end else if (left) begin
      res = x << sh;
    end else if (mode[0]) begin
      // Arithmetic right: vacated MSBs take the original operand sign.
      res = (x >> sh) | (~({WIDTH{1'b1}} >> sh) & {WIDTH{sign}});
    end else begin
      res = x >> sh;
    end
    return res;
  endfunction

  // Global stall: any held result freezes every register in the pipe.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Segment s holds mux stages [LO, HI) followed by one pipeline register.
  for (genvar s = 0; s < NREG; s++) begin : g_seg
    localparam int unsigned LO = s * REG_EVERY;
    localparam int unsigned HI = ((s + 1) * REG_EVERY < SHW) ? (s + 1) * REG_EVERY : SHW;
    localparam int unsigned NS = HI - LO;
    localparam int unsigned NA = SHW - LO;

    logic [WIDTH-1:0] d_in;
    logic [NA-1:0]    a_in;
    logic             dir_in;
    logic [1:0]       mode_in;
    logic             sign_in;
    logic [TAG_W-1:0] tag_in;
    logic             valid_in;
    logic [WIDTH-1:0] chain [NS+1];

    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;

    // Segment source: the input ports, or the previous pipeline register.
    if (s == 0) begin : g_src
      assign d_in     = in_data;
      assign a_in     = in_amnt;
      assign dir_in   = in_dir;
      assign mode_in  = in_mode;
      assign sign_in  = in_data[WIDTH-1];
      assign tag_in   = in_tag;
      assign valid_in = in_valid && in_ready;
    end else begin : g_src
      assign d_in     = g_seg[s-1].r_data;
      assign a_in     = g_seg[s-1].g_ctl.r_amnt;
      assign dir_in   = g_seg[s-1].g_ctl.r_dir;
      assign mode_in  = g_seg[s-1].g_ctl.r_mode;
      assign sign_in  = g_seg[s-1].g_ctl.r_sign;
      assign tag_in   = g_seg[s-1].r_tag;
      assign valid_in = g_seg[s-1].r_valid;
    end

    assign chain[0] = d_in;

    // Stage k = LO + j shifts by 2^k when its amount bit is set.
    for (genvar j = 0; j < NS; j++) begin : g_stage
      assign chain[j+1] = a_in[j]
                        ? shift_stage(chain[j], (1 << (LO + j)), dir_in, mode_in, sign_in)
                        : chain[j];
    end

    // Data, tag and valid register for this segment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (!stall) begin
        r_valid <= valid_in;
        r_data  <= chain[NS];
        r_tag   <= tag_in;
      end
    end

    // Control for later stages; the final segment has none left to carry.
    if (s < NREG - 1) begin : g_ctl
      logic [NA-NS-1:0] r_amnt;
      logic             r_dir;
      logic [1:0]       r_mode;
      logic             r_sign;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_amnt <= '0;
          r_dir  <= 1'b0;
          r_mode <= 2'b00;
          r_sign <= 1'b0;
        end else if (!stall) begin
          r_amnt <= a_in[NA-1:NS];
          r_dir  <= dir_in;
          r_mode <= mode_in;
          r_sign <= sign_in;
        end
      end
    end
  end

  // The final register drives the outputs directly.
  assign out_valid = g_seg[NREG-1].r_valid;
  assign out_data  = g_seg[NREG-1].r_data;
  assign out_tag   = g_seg[NREG-1].r_tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter. Two instances share the
// stimulus signals: WIDTH=32/REG_EVERY=1 (L=5) and WIDTH=8/REG_EVERY=3 (L=1).
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v, sel8, out_ready;
  logic [31:0] d;
  logic [4:0]  a;
  logic        dir;
  logic [1:0]  mode;
  logic [3:0]  tag;

  logic        in_valid_m, in_valid_8;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_data8;
  logic [3:0]  out_tag8;

  assign in_valid_m = v && !sel8;
  assign in_valid_8 = v && sel8;

  pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_m), .in_ready(in_ready),
    .in_data(d), .in_amnt(a), .in_dir(dir), .in_mode(mode), .in_tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  pipelined_barrel_shifter #(.WIDTH(8), .REG_EVERY(3), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_8), .in_ready(in_ready8),
    .in_data(d[7:0]), .in_amnt(a[2:0]), .in_dir(dir), .in_mode(mode), .in_tag(tag),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .out_tag(out_tag8)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  bit lat_en = 1'b1;
  bit use_exp = 1'b0;
  logic [31:0] exp_val = '0;

  always @(posedge clk) cyc++;

  // Reference: each result bit picked from its source bit position.
  function automatic logic [31:0] model(input logic [31:0] dd, input int aa,
                                        input logic left, input logic [1:0] mm, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (mm[1]) r[i] = left ? dd[(i - aa + w) % w] : dd[(i + aa) % w];
      else if (left) r[i] = (i >= aa) ? dd[i - aa] : 1'b0;
      else if (i + aa < w) r[i] = dd[i + aa];
      else r[i] = (mm == 2'b01) ? dd[w - 1] : 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor and acceptance capture, sampled mid-low-phase.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
        end else begin
          check("out_data", out_data, q[0].data);
          check("out_tag", 32'(out_tag), 32'(q[0].tag));
          if (out_ready) begin
            if (q[0].lat) check("latency", 32'(cyc - q[0].acc), 32'd5);
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out8: got 0x%0h, expected no output", out_data8);
        end else begin
          check("out_data8", 32'(out_data8), q8[0].data);
          check("out_tag8", 32'(out_tag8), 32'(q8[0].tag));
          if (out_ready) begin
            if (q8[0].lat) check("latency8", 32'(cyc - q8[0].acc), 32'd1);
            void'(q8.pop_front());
          end
        end
      end
      if (in_valid_m && in_ready) begin
        e.data = use_exp ? exp_val : model(d, int'(a), dir, mode, 32);
        e.tag = tag; e.acc = cyc; e.lat = lat_en;
        q.push_back(e);
        n_acc++;
      end
      if (in_valid_8 && in_ready8) begin
        e.data = use_exp ? exp_val : model(d, int'(a[2:0]), dir, mode, 8);
        e.tag = tag; e.acc = cyc; e.lat = lat_en;
        q8.push_back(e);
      end
    end
  end

  // Present one operation from a negedge until it is accepted.
  task automatic issue(input bit to8, input logic [31:0] dd, input logic [4:0] aa,
                       input logic ddir, input logic [1:0] mm, input logic [3:0] tt);
    bit rdy;
    int n;
    n = 0;
    sel8 = to8; d = dd; a = aa; dir = ddir; mode = mm; tag = tt; v = 1'b1;
    do begin
      #1;
      rdy = to8 ? in_ready8 : in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic rnd(input bit to8);
    issue(to8, $urandom, to8 ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
          1'($urandom), 2'($urandom), 4'($urandom));
  endtask

  task automatic dop(input bit to8, input logic [31:0] dd, input logic [4:0] aa,
                     input logic ddir, input logic [1:0] mm, input logic [3:0] tt,
                     input logic [31:0] ex);
    use_exp = 1'b1;
    exp_val = ex;
    issue(to8, dd, aa, ddir, mm, tt);
    use_exp = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    v = 1'b0;
    while ((q.size() != 0 || q8.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_q", 32'(q.size()), 32'd0);
    check("drain_q8", 32'(q8.size()), 32'd0);
  endtask

  initial begin
    v = 1'b0; sel8 = 1'b0; out_ready = 1'b1;
    d = '0; a = '0; dir = 1'b0; mode = 2'b00; tag = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, back to back; the first enters an empty pipe.
    dop(0, 32'h80000001, 5'd1,  1'b0, 2'b10, 4'd3,  32'hC0000000);
    dop(0, 32'h80000000, 5'd4,  1'b0, 2'b01, 4'd4,  32'hF8000000);
    dop(0, 32'h80000000, 5'd4,  1'b0, 2'b00, 4'd5,  32'h08000000);
    dop(0, 32'h12345678, 5'd8,  1'b1, 2'b10, 4'd6,  32'h34567812);
    dop(0, 32'h0000FFFF, 5'd16, 1'b1, 2'b00, 4'd7,  32'hFFFF0000);
    dop(0, 32'hC0000001, 5'd1,  1'b1, 2'b01, 4'd8,  32'h80000002);
    dop(0, 32'hDEADBEEF, 5'd0,  1'b0, 2'b11, 4'd9,  32'hDEADBEEF);
    dop(0, 32'hDEADBEEF, 5'd0,  1'b1, 2'b01, 4'd10, 32'hDEADBEEF);
    dop(0, 32'h80000000, 5'd31, 1'b0, 2'b01, 4'd11, 32'hFFFFFFFF);
    dop(0, 32'h00000001, 5'd31, 1'b0, 2'b10, 4'd12, 32'h00000002);
    dop(0, 32'hFFFFFFFF, 5'd31, 1'b1, 2'b00, 4'd13, 32'h80000000);
    drain(40);

    // Back-to-back random stream with out_ready high.
    repeat (8) rnd(0);
    drain(40);

    // Random stream with random output back-pressure.
    lat_en = 1'b0;
    fork
      begin
        repeat (80) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        repeat (40) rnd(0);
      end
    join
    out_ready = 1'b1;
    drain(60);

    // Full pipe, then three stalled cycles with an operation pending.
    repeat (5) rnd(0);
    out_ready = 1'b0;
    sel8 = 1'b0; d = $urandom; a = 5'($urandom); dir = 1'b0; mode = 2'b01; tag = 4'hA; v = 1'b1;
    repeat (3) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(0, d, a, dir, mode, tag);
    drain(40);
    check("no_loss_dup", 32'(n_out), 32'(n_acc));

    // Reset with one result held at the output and two more in flight.
    out_ready = 1'b0;
    repeat (3) rnd(0);
    v = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_tag", 32'(out_tag), 32'd0);
    n_acc -= q.size();
    q.delete();
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("post_rst_quiet", 32'(out_valid), 32'd0);
    @(negedge clk);
    lat_en = 1'b1;
    dop(0, 32'h80000001, 5'd1, 1'b0, 2'b10, 4'd3, 32'hC0000000);
    drain(40);

    // 8-bit instance with all stages ahead of a single register.
    dop(1, 32'h00000081, 5'd1, 1'b0, 2'b10, 4'd3, 32'h000000C0);
    dop(1, 32'h00000080, 5'd7, 1'b0, 2'b01, 4'd4, 32'h000000FF);
    repeat (8) rnd(1);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter. It supports rotate, logical and arithmetic shifts in either direction, with a valid/ready handshake on both sides and a tag that travels with each operation. It is the general shift engine for datapaths of any power-of-two width, and replaces fixed-width, right-rotate-only combinational shifters. Pipeline registers are placed at a configurable spacing between the log2(WIDTH) mux stages, so throughput is one operation per cycle.

Parameters:
WIDTH, 32, data width; power of two, minimum 4.
SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
REG_EVERY, 1, number of mux stages per pipeline register, 1..SHW.
TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input operation valid.
in_ready  out  1  shifter can accept an operation this cycle.
in_data  in  WIDTH  operand.
in_amnt  in  SHW  shift amount, 0..WIDTH-1.
in_dir  in  1  0 = right, 1 = left.
in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate (reserved alias).
in_tag  in  TAG_W  sideband tag, returned unmodified.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  shifted result.
out_tag  out  TAG_W  tag of the operation that produced out_data.

Behaviour:
- Reset (rst_n low, asynchronous): every pipeline valid bit, out_valid, out_data and out_tag clear to 0. Reset asserted mid-operation discards all in-flight operations with no partial outputs.
- Stage k (k = 0..SHW-1) shifts by 2^k when amnt[k] = 1, otherwise passes its input through.
- Fill rules per mode and direction:
  - Logical: vacated bits are 0.
  - Arithmetic right: vacated bits are copies of the original operand MSB. The sign is captured at input and carried down the pipe.
  - Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end enter the other end.
- Each stage's control bits (amnt, dir, mode) and the tag travel down the pipe with the data.
- Latency: L = ceil(SHW / REG_EVERY) cycles from an accepted input (in_valid && in_ready on an edge) to out_valid.
  - WIDTH = 32, REG_EVERY = 1 gives L = 5.
  - WIDTH = 32, REG_EVERY = 5 gives L = 1.
  - The last register drives the outputs directly; there is no combinational path from in_* to out_*.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational from out_ready and the output valid register only.
  - During a stall, every pipeline register, including its valid bit, holds its value. A bubble (valid = 0) does not advance while stalled; this is a global-stall design.
  - When not stalled, all stages advance each cycle. The first stage loads in_valid && in_ready together with its data.
  - While out_valid = 1, out_data and out_tag stay stable until the transfer occurs (out_valid && out_ready).
- Throughput: one operation per cycle when out_ready is held high, with no bubbles inserted.
- in_amnt = 0 returns in_data unchanged in every mode and direction.
- Data values in invalid slots are don't-care internally. out_data is only meaningful while out_valid = 1.
- Operations leave the pipeline in strict acceptance order; no reordering.

Test Plan:
- WIDTH = 32, REG_EVERY = 1: rotate right, 0x80000001 by 1, tag 3 -> exactly 5 cycles later, out_data = 0xC0000000, out_tag = 3.
- Arithmetic right, 0x80000000 by 4 -> 0xF8000000. Logical right, same operand and amount -> 0x08000000.
- Rotate left, 0x12345678 by 8 -> 0x34567812. Logical left, 0x0000FFFF by 16 -> 0xFFFF0000. Arithmetic left, 0xC0000001 by 1 -> 0x80000002.
- Back-to-back stream of 8 random operations with out_ready held high -> 8 consecutive valid outputs, each matching the reference model, tags in order.
- out_ready held low for 3 cycles while the pipe is full -> in_ready = 0 and out_data/out_tag frozen for those cycles. After release, no operation is lost or duplicated.
- Assert rst_n low with 3 operations in flight -> out_valid = 0 immediately, with no result emitted after reset release. Also rerun the rotate-right case with WIDTH = 8, REG_EVERY = 3: L = 1, 0x81 rotated right by 1 -> 0xC0.
